// File: rtl/conv_encoder_frame.sv
// conv_encoder_frame: frame-aware rate-1/2 convolutional encoder with zero-tail termination
//
// Parameters:
//   K   constraint length (3..9); the shift register holds K-1 previous bits
//   G0  generator 0, K bits; bit K-1 taps the current input bit
//   G1  generator 1, same tap ordering as G0
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready      input bit handshake; s_data is the bit, s_last ends a frame
//   m_valid/m_ready      output symbol handshake
//   m_data[1:0]          encoded symbol {d1, d0}
//   m_keep[1:0]          per-bit keep mask for the downstream packer
//   m_last               final tail symbol of a frame
//   busy                 high while terminating a frame or holding a symbol
// Optional feature macro:
//   CONV_ENC_PUNCT_EN    rate-2/3 puncturing via m_keep (11/01 alternating per frame)
module conv_encoder_frame #(
    parameter int         K  = 4,
    parameter logic [K-1:0] G0 = 4'b1011,
    parameter logic [K-1:0] G1 = 4'b1101
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       s_data,
    input  logic       s_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [1:0] m_data,
    output logic [1:0] m_keep,
    output logic       m_last,
    output logic       busy
);
    localparam int CW = $clog2(K);

    typedef enum logic {DATA, TAIL} state_t;

    state_t        state_q, state_d;
    logic [K-2:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m_valid_q, m_valid_d;
    logic [1:0]    m_data_q, m_data_d;
    logic          m_last_q, m_last_d;
    logic          slot, beat, in_bit, tail_end;
    logic [K-1:0]  w;

    always_comb begin
        // The output register can take a new symbol when empty or draining this cycle
        slot      = !m_valid_q || m_ready;
        s_ready   = (state_q == DATA) && slot;
        beat      = (state_q == DATA) ? (s_valid && s_ready) : slot;
        in_bit    = (state_q == DATA) ? s_data : 1'b0;
        w         = {in_bit, sr_q};
        tail_end  = (state_q == TAIL) && (cnt_q == CW'(K - 2));
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_valid_d = beat || (m_valid_q && !m_ready);
        if (beat) begin
            m_data_d = {^(w & G1), ^(w & G0)};
            m_last_d = tail_end;
            sr_d     = tail_end ? '0 : w[K-1:1];
            if (state_q == DATA) begin
                state_d = s_last ? TAIL : DATA;
            end else begin
                state_d = tail_end ? DATA : TAIL;
                cnt_d   = tail_end ? '0 : cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DATA;
            sr_q      <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= 2'b00;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

`ifdef CONV_ENC_PUNCT_EN
    logic       phase_q, phase_d;
    logic [1:0] m_keep_q, m_keep_d;

    // Phase restarts at 0 after each frame's final tail symbol so every frame begins with 11
    always_comb begin
        phase_d  = phase_q;
        m_keep_d = m_keep_q;
        if (beat) begin
            m_keep_d = phase_q ? 2'b01 : 2'b11;
            phase_d  = tail_end ? 1'b0 : !phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= 1'b0;
            m_keep_q <= 2'b11;
        end else begin
            phase_q  <= phase_d;
            m_keep_q <= m_keep_d;
        end
    end

    assign m_keep = m_keep_q;
`else
    assign m_keep = 2'b11;
`endif

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign busy    = (state_q == TAIL) || m_valid_q;

endmodule

// File: tb/tb_conv_encoder_frame.sv
// tb_conv_encoder_frame: scoreboard bench for conv_encoder_frame (K=4, G0=1011, G1=1101)
module tb_conv_encoder_frame;
    localparam int         K  = 4;
    localparam logic [3:0] G0 = 4'b1011;
    localparam logic [3:0] G1 = 4'b1101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       s_data = 1'b0;
    logic       s_last = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [1:0] m_data;
    logic [1:0] m_keep;
    logic       m_last;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;
    bit sb_off = 1'b0;

    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];
    int         xfer_cyc[$];

    conv_encoder_frame #(.K(K), .G0(G0), .G1(G1)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
        .m_last(m_last), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        logic [3:0] pat;
        int pidx;
        pat = 4'b1001;
        pidx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) m_ready = 1'b1;
            else if (ready_mode == 1) begin
                m_ready = pat[pidx % 4];
                pidx++;
            end else m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on each completed transfer and checks hold under backpressure
    initial begin
        logic [5:0] prev;
        logic [4:0] got, exp;
        bit have_prev;
        have_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) have_prev = 1'b0;
            else begin
                if (have_prev) begin
                    checks++;
                    if ({m_data, m_keep, m_last, m_valid} !== prev) begin
                        failures++;
                        $display("FAIL stall_hold: got {data,keep,last,valid}=%b required %b", {m_data, m_keep, m_last, m_valid}, prev);
                    end
                end
                have_prev = m_valid && !m_ready;
                prev = {m_data, m_keep, m_last, m_valid};
                if (m_valid && m_ready && !sb_off) begin
                    got = {m_last, m_keep, m_data};
                    obs_q.push_back(got);
                    xfer_cyc.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL symbol: unexpected {last,keep,data}=%b with empty scoreboard", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            failures++;
                            $display("FAIL symbol: got {last,keep,data}=%b required %b", got, exp);
                        end
                    end
                end
            end
        end
    end

    task automatic push_frame(input logic [15:0] bits, input int n);
        logic [K-2:0] sr;
        logic [K-1:0] w;
        logic ph, lst;
        logic [1:0] keep;
        sr = '0;
        ph = 1'b0;
        for (int i = 0; i < n + K - 1; i++) begin
            w = {(i < n) ? bits[i] : 1'b0, sr};
            sr = w[K-1:1];
            lst = (i == n + K - 2);
`ifdef CONV_ENC_PUNCT_EN
            keep = ph ? 2'b01 : 2'b11;
`else
            keep = 2'b11;
`endif
            ph = ~ph;
            exp_q.push_back({lst, keep, ^(w & G1), ^(w & G0)});
        end
    endtask

    task automatic drive_frame(input logic [15:0] bits, input int n);
        bit acc;
        push_frame(bits, n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data = bits[i];
            s_last = (i == n - 1);
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
            end
            checks++;
            if (!acc) begin
                failures++;
                $display("FAIL accept bit %0d: s_ready stayed 0, required 1 within 100 cycles", i);
            end
        end
        s_last = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            failures++;
            $display("FAIL %s drain: outstanding=%0d busy=%b required 0 and 0", name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_data, m_keep, m_last, busy} !== 8'b1_0_00_11_0_0) begin
            failures++;
            $display("FAIL reset_values: got {s_ready,m_valid,m_data,m_keep,m_last,busy}=%b required 10001100",
                     {s_ready, m_valid, m_data, m_keep, m_last, busy});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [1:0] ed[7];
        logic [1:0] ek[7];
        ed = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11};
`ifdef CONV_ENC_PUNCT_EN
        ek = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11};
`else
        ek = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
`endif
        ready_mode = 0;
        obs_q.delete();
        drive_frame(16'b1101, 4);
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0) begin
                failures++;
                $display("FAIL tail_s_ready cycle %0d: got %b required 0", i, s_ready);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_tail_s_ready: got %b required 1", s_ready);
        end
        wait_drain("basic");
        checks++;
        if (obs_q.size() != 7) begin
            failures++;
            $display("FAIL basic_count: got %0d symbols required 7", obs_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (obs_q[i] !== {i == 6, ek[i], ed[i]}) begin
                    failures++;
                    $display("FAIL basic_sym %0d: got {last,keep,data}=%b required %b", i, obs_q[i], {i == 6, ek[i], ed[i]});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        ready_mode = 1;
        obs_q.delete();
        drive_frame(16'b1101, 4);
        s_valid = 1'b0;
        wait_drain("backpressure");
        checks++;
        if (obs_q.size() != 7) begin
            failures++;
            $display("FAIL backpressure_count: got %0d symbols required 7", obs_q.size());
        end
        ready_mode = 0;
    endtask

    task automatic test_single_bit();
        ready_mode = 0;
        obs_q.delete();
        drive_frame(16'b1, 1);
        s_valid = 1'b0;
        wait_drain("single");
        checks++;
        if (obs_q.size() != 4 || obs_q[3][4] !== 1'b1 || obs_q[0][1:0] !== 2'b11) begin
            failures++;
            $display("FAIL single_frame: got %0d symbols, last flag %b, first data %b required 4, 1, 11",
                     obs_q.size(), obs_q.size() == 4 ? obs_q[3][4] : 1'bx, obs_q.size() > 0 ? obs_q[0][1:0] : 2'bxx);
        end
    endtask

    task automatic test_back_to_back();
        ready_mode = 0;
        xfer_cyc.delete();
        drive_frame(16'b1101, 4);
        drive_frame(16'b0110, 4);
        s_valid = 1'b0;
        wait_drain("back_to_back");
        checks++;
        if (xfer_cyc.size() != 14 || xfer_cyc[xfer_cyc.size() - 1] - xfer_cyc[0] != 13) begin
            failures++;
            $display("FAIL back_to_back_gapless: got %0d symbols over span %0d required 14 over 13",
                     xfer_cyc.size(), xfer_cyc.size() > 0 ? xfer_cyc[xfer_cyc.size() - 1] - xfer_cyc[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int t;
        ready_mode = 0;
        sb_off = 1'b1;
        acc = 0;
        t = 0;
        s_valid = 1'b1;
        s_data = 1'b1;
        s_last = 1'b0;
        while (acc < 2 && t < 50) begin
            @(negedge clk);
            if (s_ready) acc++;
            @(posedge clk);
            #1;
            s_data = 1'b0;
            t++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, s_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL reset_mid: got {m_valid,s_ready,busy}=%b required 010", {m_valid, s_ready, busy});
        end
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_off = 1'b0;
        test_basic();
    endtask

    task automatic test_random();
        int n;
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 12);
            drive_frame(16'($urandom), n);
        end
        s_valid = 1'b0;
        wait_drain("random");
        ready_mode = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_single_bit();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
